sum_result_fifo: RTL and testbench

//   Result buffer directly downstream of the one-cycle adder stage (y/valid producer).
//   - Captures each single-cycle sum pulse, which has no backpressure, into a DEPTH-entry FIFO.
//   - Presents the buffered sums to the consumer over a valid/ready handshake.
//   - Flags sums lost to overflow in a sticky status bit.

---
 rtl/sum_result_fifo.sv | 107 ++++++++++
 tb/tb_sum_result_fifo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sum_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sum_result_fifo
// Brief    : DEPTH-entry first-word-fall-through result buffer placed after
//            the one-cycle adder stage. Captures unthrottled sum pulses,
//            hands them to the consumer over valid/ready and records dropped
//            sums in a sticky overflow flag.
// Options  : define SUM_FIFO_ACC_EN to add the 'acc' port, a running
//            modulo-2^ACC_W sum of every popped value.
// Revision : 1.0  initial release
// ============================================================================
module sum_result_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4,
  parameter int ACC_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_ovf
`ifdef SUM_FIFO_ACC_EN
  ,
  output logic [ACC_W-1:0]         acc
`endif
);

  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW:0] c_ONE = {{c_AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [c_AW:0]   r_wr_ptr;
  logic [c_AW:0]   r_rd_ptr;
  logic [c_AW:0]   r_level;
  logic            r_overflow;
  logic [W-1:0]    r_mem [DEPTH];

  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_ovf_evt;
  logic [c_AW-1:0] w_wr_idx;
  logic [c_AW-1:0] w_rd_idx;

  assign w_wr_idx  = r_wr_ptr[c_AW-1:0];
  assign w_rd_idx  = r_rd_ptr[c_AW-1:0];
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (w_wr_idx == w_rd_idx) && (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);
  assign w_pop     = !w_empty && out_ready;
  // A full buffer still accepts a sum when the head leaves in the same cycle.
  assign w_push    = in_valid && (!w_full || w_pop);
  assign w_ovf_evt = in_valid && w_full && !w_pop;

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : r_mem[w_rd_idx];
  assign level     = r_level;
  assign overflow  = r_overflow;

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_ONE;
        2'b01:   r_level <= r_level - c_ONE;
        default: r_level <= r_level;
      endcase
      // A new drop in the same cycle as a clear leaves the flag set.
      if (w_ovf_evt)    r_overflow <= 1'b1;
      else if (clr_ovf) r_overflow <= 1'b0;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_wr_idx] <= in_data;
  end

`ifdef SUM_FIFO_ACC_EN
  logic [ACC_W-1:0] r_acc;
  assign acc = r_acc;

  // Running sum of every value handed to the consumer, wrapping at 2^ACC_W.
  always_ff @(posedge clk) begin
    if (rst)        r_acc <= '0;
    else if (w_pop) r_acc <= r_acc + {{(ACC_W-W){1'b0}}, out_data};
  end
`else
  // Accumulator absent; ACC_W only keeps one parameter list for both builds.
  if (ACC_W < 1) begin : g_acc_absent
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sum_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_result_fifo
// Brief    : Self-checking bench for sum_result_fifo (DEPTH=4, W=20): directed
//            vector table, hand-written reset sequence and a randomized run
//            against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sum_result_fifo;

  localparam int W     = 20;
  localparam int DEPTH = 4;
  localparam int ACC_W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [2:0]    level;
  logic          overflow;
  logic          clr_ovf;
`ifdef SUM_FIFO_ACC_EN
  logic [ACC_W-1:0] acc;
`endif

  int n_checks = 0;
  int n_err    = 0;

  sum_result_fifo #(.W(W), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
`ifdef SUM_FIFO_ACC_EN
    ,
    .acc       (acc)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst; bit iv; int d; bit rdy; bit clr;
    bit ev; int ed; int el; bit eo;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit iv, input int d, input bit rdy, input bit clr,
                     input bit ev, input int ed, input int el, input bit eo);
    vec_t v;
    v.rst = r; v.iv = iv; v.d = d; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ed = ed; v.el = el; v.eo = eo;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then sample #1 later.
  task automatic drive(input bit r, input bit iv, input int d, input bit rdy, input bit clr);
    rst = r; in_valid = iv; in_data = d[W-1:0]; out_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic fill4();
    add(0,1,1,0,0, 1,1,1,0);
    add(0,1,2,0,0, 1,1,2,0);
    add(0,1,3,0,0, 1,1,3,0);
    add(0,1,4,0,0, 1,1,4,0);
  endtask

  // Reference model state for the randomized run.
  int unsigned   q[$];
  bit            m_ovf;
  bit [ACC_W-1:0] m_acc;

  initial begin
    bit [ACC_W-1:0] t_acc;
    bit prev_ev;
    int prev_ed;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;

    // Reset with stimulus present: nothing captured.
    add(1,1,3,0,0, 0,0,0,0);
    add(1,1,3,0,0, 0,0,0,0);
    add(1,1,3,0,0, 0,0,0,0);
    // Two pushes, then drain; extra ready while empty is ignored.
    add(0,1,5,0,0, 1,5,1,0);
    add(0,1,7,0,0, 1,5,2,0);
    add(0,0,0,1,0, 1,7,1,0);
    add(0,0,0,1,0, 0,0,0,0);
    add(0,0,0,1,0, 0,0,0,0);
    // Overflow drops 9; drain yields 1..4; then clear.
    fill4();
    add(0,1,9,0,0, 1,1,4,1);
    add(0,0,0,1,0, 1,2,3,1);
    add(0,0,0,1,0, 1,3,2,1);
    add(0,0,0,1,0, 1,4,1,1);
    add(0,0,0,1,0, 0,0,0,1);
    add(0,0,0,0,1, 0,0,0,0);
    // Full with simultaneous push and pop: 9 accepted.
    fill4();
    add(0,1,9,1,0, 1,2,4,0);
    add(0,0,0,1,0, 1,3,3,0);
    add(0,0,0,1,0, 1,4,2,0);
    add(0,0,0,1,0, 1,9,1,0);
    add(0,0,0,1,0, 0,0,0,0);
    // Drop and clear in the same cycle: set wins; then clear alone.
    fill4();
    add(0,1,9,0,1, 1,1,4,1);
    add(0,0,0,0,1, 1,1,4,0);
    add(0,0,0,1,0, 1,2,3,0);
    add(0,0,0,1,0, 1,3,2,0);
    add(0,0,0,1,0, 1,4,1,0);
    add(0,0,0,1,0, 0,0,0,0);

    t_acc = '0; prev_ev = 1'b0; prev_ed = 0;
    foreach (tbl[i]) begin
      if (tbl[i].rst) t_acc = '0;
      else if (tbl[i].rdy && prev_ev) t_acc = t_acc + prev_ed;
      drive(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].ev);
      chk($sformatf("vec%0d out_data", i), out_data, tbl[i].ed);
      chk($sformatf("vec%0d level", i), level, tbl[i].el);
      chk($sformatf("vec%0d overflow", i), overflow, tbl[i].eo);
`ifdef SUM_FIFO_ACC_EN
      chk($sformatf("vec%0d acc", i), acc, t_acc);
`endif
      prev_ev = tbl[i].ev; prev_ed = tbl[i].ed;
    end

    // Reset mid-stream flushes three entries; a later push comes out intact.
    drive(0,1,10,0,0);
    drive(0,1,20,0,0);
    drive(0,1,30,0,0);
    chk("flush pre level", level, 3);
    drive(1,0,0,1,0);
    chk("flush level", level, 0);
    chk("flush out_valid", out_valid, 0);
    chk("flush out_data", out_data, 0);
`ifdef SUM_FIFO_ACC_EN
    chk("flush acc", acc, 0);
`endif
    drive(0,1,42,0,0);
    chk("post flush data", out_data, 42);
    chk("post flush level", level, 1);
    drive(0,0,0,1,0);
    chk("post flush empty", out_valid, 0);
`ifdef SUM_FIFO_ACC_EN
    chk("post flush acc", acc, 42);
`endif

    // Randomized run against the queue model (model starts from the state above).
    q.delete(); m_ovf = 1'b0; m_acc = 42;
    for (int c = 0; c < 3000; c++) begin
      bit r, iv, rdy, clr, pop, push;
      int d;
      r   = ($urandom_range(0, 99) == 0);
      iv  = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 9) < 4);
      clr = ($urandom_range(0, 15) == 0);
      d   = int'($urandom & 32'h000F_FFFF);
      if (r) begin
        q.delete(); m_ovf = 1'b0; m_acc = '0;
      end else begin
        pop  = (q.size() > 0) && rdy;
        push = iv && ((q.size() < DEPTH) || pop);
        if (iv && !push) m_ovf = 1'b1;
        else if (clr)    m_ovf = 1'b0;
        if (pop) begin
          m_acc = m_acc + q[0];
          void'(q.pop_front());
        end
        if (push) q.push_back(d);
      end
      drive(r, iv, d, rdy, clr);
      chk("rand out_valid", out_valid, q.size() > 0);
      chk("rand out_data", out_data, (q.size() > 0) ? q[0] : 0);
      chk("rand level", level, q.size());
      chk("rand overflow", overflow, m_ovf);
`ifdef SUM_FIFO_ACC_EN
      chk("rand acc", acc, m_acc);
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
